// File: rtl/stream_upsample.sv
// Nearest-neighbour upsampler: rebuilds a level-0 raster from sparse level-LEVEL samples via a ping-pong line memory.
// Optional sample-phase checker (err_phase output) enabled by defining STREAM_UPSAMPLE_PHASE_CHECK_EN.
`timescale 1ns/1ps
module stream_upsample #(
    parameter int BIT_WIDTH    = 8,
    parameter int IMAGE_HEIGHT = 480,
    parameter int IMAGE_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 500,
    parameter int FRAME_WIDTH  = 800,
    parameter int LEVEL        = 1
) (
    input  logic                 clock,
    input  logic                 n_rst,
    input  logic                 enable,
    input  logic [BIT_WIDTH-1:0] in_pixel,
    input  logic                 in_enable,
    input  logic [8:0]           in_vcnt,
    input  logic [9:0]           in_hcnt,
    output logic [BIT_WIDTH-1:0] out_pixel,
    output logic [8:0]           out_vcnt,
    output logic [9:0]           out_hcnt,
`ifdef STREAM_UPSAMPLE_PHASE_CHECK_EN
    output logic                 err_phase,
`endif
    output logic                 out_primed
);

    localparam int         DEPTH  = IMAGE_WIDTH >> LEVEL;
    localparam int         AW     = (DEPTH > 32'sd1) ? $clog2(DEPTH) : 32'sd1;
    localparam logic [8:0] V_MASK = 9'((32'sd1 << LEVEL) - 32'sd1);
    localparam logic [9:0] H_MASK = 10'((32'sd1 << LEVEL) - 32'sd1);
    localparam logic [8:0] V_STEP = 9'(32'sd1 << LEVEL);
    localparam logic [8:0] V_WRAP = 9'(FRAME_HEIGHT - (32'sd1 << LEVEL));
    localparam logic [8:0] IMG_H  = 9'(IMAGE_HEIGHT);
    localparam logic [9:0] IMG_W  = 10'(IMAGE_WIDTH);
    localparam logic [9:0] H_LAST = 10'(FRAME_WIDTH - 32'sd1);

    logic [BIT_WIDTH-1:0] bank0_r [DEPTH];
    logic [BIT_WIDTH-1:0] bank1_r [DEPTH];
    logic                 sel_r;
    logic                 written_r;

    logic [AW-1:0]        addr_s;
    logic                 wr_s;
    logic                 toggle_s;
    logic [8:0]           vnext_s;
    logic                 out_inside_s;
    logic [BIT_WIDTH-1:0] rd_s;

    // Address, write/toggle decode and next output line coordinate.
    always_comb begin
        addr_s   = AW'(in_hcnt >> LEVEL);
        wr_s     = in_enable && (in_vcnt < IMG_H) && (in_hcnt < IMG_W);
        // A toggle closes each block row; with LEVEL=0 the mask is empty so every line end toggles.
        toggle_s = (in_hcnt == H_LAST) && ((in_vcnt & V_MASK) == V_MASK);
        if (in_vcnt >= V_STEP) begin
            vnext_s = in_vcnt - V_STEP;
        end else begin
            vnext_s = in_vcnt + V_WRAP;
        end
        out_inside_s = (vnext_s < IMG_H) && (in_hcnt < IMG_W);
    end

    // Read port: the bank not currently being written.
    always_comb begin
        rd_s = {BIT_WIDTH{1'b0}};
        if (sel_r) begin
            rd_s = bank0_r[addr_s];
        end else begin
            rd_s = bank1_r[addr_s];
        end
    end

    // Line memory write port; contents intentionally not reset.
    always_ff @(posedge clock) begin
        if (enable && wr_s) begin
            if (sel_r) begin
                bank1_r[addr_s] <= in_pixel;
            end else begin
                bank0_r[addr_s] <= in_pixel;
            end
        end
    end

    // Bank control and registered output stream.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            out_pixel  <= {BIT_WIDTH{1'b0}};
            out_vcnt   <= 9'd0;
            out_hcnt   <= 10'd0;
            out_primed <= 1'b0;
            sel_r      <= 1'b0;
            written_r  <= 1'b0;
        end else if (enable) begin
            out_vcnt  <= vnext_s;
            out_hcnt  <= in_hcnt;
            out_pixel <= (out_inside_s && out_primed) ? rd_s : {BIT_WIDTH{1'b0}};
            if (toggle_s) begin
                sel_r      <= ~sel_r;
                out_primed <= written_r;
                written_r  <= 1'b0;
            end else if (wr_s) begin
                written_r  <= 1'b1;
            end
        end
    end

`ifdef STREAM_UPSAMPLE_PHASE_CHECK_EN
    logic phase_bad_s;

    // A sample is misplaced unless it sits at the bottom-right of its block.
    always_comb begin
        phase_bad_s = ((in_vcnt & V_MASK) != V_MASK) || ((in_hcnt & H_MASK) != H_MASK);
    end

    // Sticky phase error flag, cleared only by reset.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            err_phase <= 1'b0;
        end else if (enable && in_enable && phase_bad_s) begin
            err_phase <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_upsample.sv
// Directed bench for stream_upsample: LEVEL=1 raster table with stall/out-of-image cases, mid-frame reset,
// LEVEL=0 ramp, and the optional phase checker when STREAM_UPSAMPLE_PHASE_CHECK_EN is defined.
`timescale 1ns/1ps
module tb_stream_upsample;

    logic       clock = 1'b0;
    logic       n_rst;
    logic       enable;
    logic [7:0] in_pixel;
    logic       in_enable;
    logic [8:0] in_vcnt;
    logic [9:0] in_hcnt;
    logic [7:0] out_pixel;
    logic [8:0] out_vcnt;
    logic [9:0] out_hcnt;
    logic       out_primed;

    logic [7:0] z_in_pixel;
    logic       z_in_enable;
    logic [8:0] z_in_vcnt;
    logic [9:0] z_in_hcnt;
    logic [7:0] z_out_pixel;
    logic [8:0] z_out_vcnt;
    logic [9:0] z_out_hcnt;
    logic       z_out_primed;
`ifdef STREAM_UPSAMPLE_PHASE_CHECK_EN
    logic       err_phase;
    logic       z_err_phase;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int v; int h; bit en; int pix;
        int ov; int oh; int opix; bit oprim; bit chk_pix;
    } vec_t;

    vec_t tbl[$];
    int   stall_idx;

    stream_upsample #(.BIT_WIDTH(8), .IMAGE_HEIGHT(4), .IMAGE_WIDTH(8),
                      .FRAME_HEIGHT(6), .FRAME_WIDTH(10), .LEVEL(1)) dut (
        .clock(clock), .n_rst(n_rst), .enable(enable),
        .in_pixel(in_pixel), .in_enable(in_enable), .in_vcnt(in_vcnt), .in_hcnt(in_hcnt),
        .out_pixel(out_pixel), .out_vcnt(out_vcnt), .out_hcnt(out_hcnt),
`ifdef STREAM_UPSAMPLE_PHASE_CHECK_EN
        .err_phase(err_phase),
`endif
        .out_primed(out_primed)
    );

    stream_upsample #(.BIT_WIDTH(8), .IMAGE_HEIGHT(4), .IMAGE_WIDTH(8),
                      .FRAME_HEIGHT(6), .FRAME_WIDTH(10), .LEVEL(0)) dut0 (
        .clock(clock), .n_rst(n_rst), .enable(enable),
        .in_pixel(z_in_pixel), .in_enable(z_in_enable), .in_vcnt(z_in_vcnt), .in_hcnt(z_in_hcnt),
        .out_pixel(z_out_pixel), .out_vcnt(z_out_vcnt), .out_hcnt(z_out_hcnt),
`ifdef STREAM_UPSAMPLE_PHASE_CHECK_EN
        .err_phase(z_err_phase),
`endif
        .out_primed(z_out_primed)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Primed state after the edge at raster position p = v*10+h (LEVEL=1 setup, samples in lines 1 and 3).
    function automatic bit prim1(int p);
        return (p >= 19) && (p < 59);
    endfunction

    function automatic vec_t mk1(int v, int h, bit en, int pix);
        vec_t r;
        int p;
        int ov;
        p  = v * 10 + h;
        ov = (v >= 2) ? v - 2 : v + 4;
        r.v = v; r.h = h; r.en = en; r.pix = pix;
        r.ov = ov; r.oh = h; r.oprim = prim1(p); r.chk_pix = 1'b1;
        r.opix = (ov < 4 && h < 8 && p > 0 && prim1(p - 1)) ? 16 * (ov / 2) + h / 2 : 0;
        return r;
    endfunction

    function automatic vec_t mk_raster(int v, int h);
        bit en;
        en = (v < 4) && (h < 8) && (v % 2 == 1) && (h % 2 == 1);
        return mk1(v, h, en, en ? 16 * (v / 2) + h / 2 : 32'h5A);
    endfunction

    task automatic apply(input vec_t t);
        string tag;
        tag = $sformatf("v%0d h%0d", t.v, t.h);
        in_vcnt = 9'(t.v); in_hcnt = 10'(t.h); in_enable = t.en; in_pixel = 8'(t.pix);
        @(posedge clock); #1;
        check({tag, " out_vcnt"}, 32'(out_vcnt), 32'(t.ov));
        check({tag, " out_hcnt"}, 32'(out_hcnt), 32'(t.oh));
        if (t.chk_pix) check({tag, " out_pixel"}, 32'(out_pixel), 32'(t.opix));
        check({tag, " out_primed"}, 32'(out_primed), 32'(t.oprim));
    endtask

    task automatic stall(input vec_t p);
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_vcnt = 9'd3; in_hcnt = (k % 2 == 1) ? 10'd9 : 10'd3;
            in_enable = 1'b1; in_pixel = 8'hEE;
            @(posedge clock); #1;
            check($sformatf("stall%0d out_vcnt", k), 32'(out_vcnt), 32'(p.ov));
            check($sformatf("stall%0d out_hcnt", k), 32'(out_hcnt), 32'(p.oh));
            check($sformatf("stall%0d out_pixel", k), 32'(out_pixel), 32'(p.opix));
            check($sformatf("stall%0d out_primed", k), 32'(out_primed), 32'(p.oprim));
        end
        enable = 1'b1;
    endtask

    initial begin
        vec_t t;
        n_rst = 1'b0; enable = 1'b1;
        in_pixel = 8'h00; in_enable = 1'b0; in_vcnt = 9'd0; in_hcnt = 10'd0;
        z_in_pixel = 8'h00; z_in_enable = 1'b0; z_in_vcnt = 9'd0; z_in_hcnt = 10'd0;

        // Build the LEVEL=1 table: 3 frames, with out-of-image samples after the last row-0 write of frame 2.
        for (int f = 0; f < 3; f++)
            for (int v = 0; v < 6; v++)
                for (int h = 0; h < 10; h++) begin
                    if (f == 1 && v == 3 && h == 4) stall_idx = tbl.size();
                    tbl.push_back(mk_raster(v, h));
                    if (f == 1 && v == 1 && h == 7) begin
                        t = mk1(20, 3, 1'b1, 32'hAA);   t.opix = 0; t.oprim = prim1(17); tbl.push_back(t);
                        t = mk1(20, 100, 1'b1, 32'hAA); t.opix = 0; t.oprim = prim1(17); tbl.push_back(t);
                    end
                end

        // Reset state.
        #12;
        check("reset out_pixel", 32'(out_pixel), 32'h0);
        check("reset out_vcnt", 32'(out_vcnt), 32'h0);
        check("reset out_hcnt", 32'(out_hcnt), 32'h0);
        check("reset out_primed", 32'(out_primed), 32'h0);
        check("reset z_out_primed", 32'(z_out_primed), 32'h0);
        @(negedge clock); n_rst = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < tbl.size(); i++) begin
            if (i == stall_idx) stall(tbl[i - 1]);
            apply(tbl[i]);
        end

        // Mid-frame reset at line 3 pixel 4.
        for (int v = 0; v < 4; v++)
            for (int h = 0; h < 10; h++)
                if (v < 3 || h < 4) apply(mk_raster(v, h));
        n_rst = 1'b0; #1;
        check("midreset out_pixel", 32'(out_pixel), 32'h0);
        check("midreset out_vcnt", 32'(out_vcnt), 32'h0);
        check("midreset out_hcnt", 32'(out_hcnt), 32'h0);
        check("midreset out_primed", 32'(out_primed), 32'h0);
        #1; n_rst = 1'b1;
        for (int h = 4; h < 10; h++) begin
            t = mk_raster(3, h); t.opix = 0; t.oprim = (h == 9); apply(t);
        end
        for (int v = 4; v < 6; v++)
            for (int h = 0; h < 10; h++) begin
                t = mk_raster(v, h); t.chk_pix = (h >= 4); apply(t);
            end
        for (int v = 0; v < 6; v++)
            for (int h = 0; h < 10; h++) apply(mk_raster(v, h));

        // LEVEL=0 ramp on the second instance.
        in_enable = 1'b0; in_vcnt = 9'd0; in_hcnt = 10'd0;
        for (int f = 0; f < 2; f++)
            for (int v = 0; v < 6; v++)
                for (int h = 0; h < 10; h++) begin
                    int ov;
                    string tag;
                    ov  = (v >= 1) ? v - 1 : 5;
                    tag = $sformatf("L0 f%0d v%0d h%0d", f, v, h);
                    z_in_vcnt = 9'(v); z_in_hcnt = 10'(h); z_in_enable = 1'b1; z_in_pixel = 8'(h);
                    @(posedge clock); #1;
                    check({tag, " out_vcnt"}, 32'(z_out_vcnt), 32'(ov));
                    check({tag, " out_hcnt"}, 32'(z_out_hcnt), 32'(h));
                    check({tag, " out_pixel"}, 32'(z_out_pixel), (ov < 4 && h < 8) ? 32'(h) : 32'h0);
                    check({tag, " out_primed"}, 32'(z_out_primed),
                          (h == 9) ? 32'(v < 4) : 32'(v >= 1 && v <= 4));
                end
        z_in_enable = 1'b0;

`ifdef STREAM_UPSAMPLE_PHASE_CHECK_EN
        check("err_phase before", 32'(err_phase), 32'h0);
        check("z_err_phase", 32'(z_err_phase), 32'h0);
        in_vcnt = 9'd1; in_hcnt = 10'd2; in_enable = 1'b1; in_pixel = 8'h77;
        @(posedge clock); #1;
        check("err_phase set", 32'(err_phase), 32'h1);
        in_enable = 1'b0; in_vcnt = 9'd1; in_hcnt = 10'd3;
        repeat (3) @(posedge clock);
        #1;
        check("err_phase sticky", 32'(err_phase), 32'h1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
